// File: rtl/led_status_pkg.sv
// led_status_pkg: shared state encoding, ASCII constants and message byte lookup.
// LED_STATUS_TX_PARITY_EN adds the PARITY serialiser state.
package led_status_pkg;

`ifdef LED_STATUS_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

    localparam logic [7:0] QUERY = 8'd63;
    localparam logic [7:0] HDR   = 8'd76;
    localparam logic [7:0] ZERO  = 8'd48;
    localparam logic [7:0] ONE   = 8'd49;
    localparam logic [7:0] CR    = 8'd13;
    localparam logic [7:0] LF    = 8'd10;
    localparam int         MSG_LEN = 7;

    // Bytes 1..4 report snap[3]..snap[0]; 0 - idx (mod 4) maps 1,2,3,4 to 3,2,1,0.
    function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [3:0] snap);
        logic [1:0] b;
        b = 2'd0 - idx[1:0];
        return idx == 3'd0 ? HDR :
               idx <= 3'd4 ? (snap[b] ? ONE : ZERO) :
               idx == 3'd5 ? CR : LF;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte UART serialiser with baud counter and registered Tx.
// LED_STATUS_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_byte
    import led_status_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       Tx
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;
    logic          bit_end;
`ifdef LED_STATUS_TX_PARITY_EN
    logic          parity;
`endif

    assign bit_end = baud == LAST;
    // Ready on the final stop-bit cycle lets the next start bit follow with no gap.
    assign ready   = state == IDLE || (state == STOP && bit_end);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shifter <= '0;
            Tx      <= 1'b1;
`ifdef LED_STATUS_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
            if (ready && start) begin
                state   <= START;
                shifter <= data;
                bit_idx <= '0;
                Tx      <= 1'b0;
`ifdef LED_STATUS_TX_PARITY_EN
                parity  <= ^data;
`endif
            end else begin
                case (state)
                    START: if (bit_end) begin
                        state <= DATA;
                        Tx    <= shifter[0];
                    end
                    DATA: if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef LED_STATUS_TX_PARITY_EN
                            state <= PARITY;
                            Tx    <= parity;
`else
                            state <= STOP;
                            Tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shifter <= shifter >> 1;
                            Tx      <= shifter[1];
                        end
                    end
`ifdef LED_STATUS_TX_PARITY_EN
                    PARITY: if (bit_end) begin
                        state <= STOP;
                        Tx    <= 1'b1;
                    end
`endif
                    STOP: if (bit_end) state <= IDLE;
                    default: begin
                        state <= IDLE;
                        Tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/led_status_tx.sv
// led_status_tx: answers '?' with "Lbbbb\r\n" reporting a snapshot of LedState over UART.
// LED_STATUS_TX_PARITY_EN (in uart_tx_byte) selects 8E1 framing.
module led_status_tx
    import led_status_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [7:0] Cmd,
    input  logic       CmdValid,
    input  logic [3:0] LedState,
    output logic       Tx,
    output logic       Busy
);

    logic [2:0] byte_idx;
    logic [3:0] snapshot;
    logic       tx_ready;
    logic       msg_done;
    logic       accept;
    logic       next_byte;
    logic [2:0] sel;
    logic [7:0] tx_data;

    // A query landing on the edge that ends the last stop bit is taken immediately.
    assign msg_done  = Busy && tx_ready && byte_idx == 3'(MSG_LEN - 1);
    assign accept    = CmdValid && Cmd == QUERY && (!Busy || msg_done);
    assign next_byte = Busy && tx_ready && !msg_done;
    assign sel       = accept ? 3'd0 : byte_idx + 3'd1;
    assign tx_data   = msg_byte(sel, snapshot);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Busy     <= 1'b0;
            byte_idx <= '0;
            snapshot <= '0;
        end else if (accept) begin
            Busy     <= 1'b1;
            byte_idx <= '0;
            snapshot <= LedState;
        end else if (next_byte) begin
            byte_idx <= sel;
        end else if (msg_done) begin
            Busy     <= 1'b0;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .data    (tx_data),
        .start   (accept || next_byte),
        .ready   (tx_ready),
        .Tx      (Tx)
    );

endmodule

// File: doc/led_status_tx.md
# led_status_tx

Status reporter for the LED command path: a UART transmitter that returns the board's LED state to the host. It watches the same 8-bit command byte stream that drives the LED toggle FSMs. On the query character '?' it serialises a 7-byte ASCII status line on Tx at a fixed baud rate. It sits beside the toggle FSMs, fed by the UART receiver's byte/strobe output.

## Interface
- CLKS_PER_BIT, 868, Clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- Clock  in  1  system clock; all logic on posedge.
- Reset_n  in  1  reset, asynchronous and active-low.
- Cmd  in  8  received command byte.
- CmdValid  in  1  single-cycle strobe qualifying Cmd.
- LedState  in  4  current LED states, bit 3 first in the report.
- Tx  out  1  UART serial output, idle high.
- Busy  out  1  high from query acceptance until the last stop bit completes.

## Operation
- Query accept:
  - Occurs on a Clock edge with CmdValid=1, Cmd=63 ('?') and Busy=0.
  - LedState is snapshotted at that edge; later changes do not affect the message in flight.
- Queries while Busy=1 are dropped, with no queueing. All other Cmd values are ignored.
- Message is 7 bytes, in this order:
  - 'L' (76)
  - four bytes for snapshot bits 3..0, each 49 ('1') if the bit is 1, else 48 ('0')
  - CR (13)
  - LF (10)
- Frame format:
  - 1 start bit (0)
  - 8 data bits, LSB first
  - 1 stop bit (1)
  - the optional parity bit (see Configuration) goes between data and stop.
- Serialiser FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
  - IDLE→START on accept, or on STOP completion when more bytes remain.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP (or PARITY) after 8 bits.
  - STOP→IDLE after the last byte.
- Counters:
  - Baud counter is clog2(CLKS_PER_BIT) bits wide and runs 0..CLKS_PER_BIT-1, wrapping on bit boundaries.
  - Bit index runs 0..7.
  - Byte index runs 0..6; it does not wrap, and the message terminates at 6.
- Reset (any time, including mid-frame):
  - Tx=1 and Busy=0 immediately (asynchronous).
  - FSM goes to IDLE; all counters and the snapshot clear to 0.
  - After Reset_n rises, the first accept sends a fresh full message.

## Timing
- Reset values: Tx=1, Busy=0.
- Accept edge N: Busy=1 and Tx=0 (start bit) from edge N+1.
- Every bit is exactly CLKS_PER_BIT cycles.
- Bytes are back-to-back with no idle gap; the next start bit follows the stop bit directly.
- Frame lengths:
  - 10·CLKS_PER_BIT cycles per frame, 11·CLKS_PER_BIT with parity.
  - Full message: 70·CLKS_PER_BIT cycles (77·CLKS_PER_BIT with parity).
- Busy falls on the edge that ends the last stop bit.
  - A query on that same edge is accepted: Busy stays 1 and Tx goes 0 on the next cycle.
- Tx is registered, with no combinational path from inputs to Tx.

## Configuration
- LED_STATUS_TX_PARITY_EN defined:
  - an even-parity bit (XOR of the 8 data bits) is sent after bit 7;
  - frame is 11 bits.
- Undefined: no PARITY state, 10-bit frames, 8N1.

## Structure
- Package led_status_pkg holds:
  - FSM state encoding
  - ASCII constants: QUERY=63, HDR='L'=76, ZERO=48, ONE=49, CR=13, LF=10
  - MSG_LEN=7
- Sub-module uart_tx_byte:
  - contains the baud counter, bit shifter, start/stop/parity sequencing and the Tx register;
  - handshake is byte/start in and ready out.
- led_status_tx owns query detection, the snapshot, the byte index/mux and Busy.

## Test plan
(All cases use CLKS_PER_BIT=4.)
- After reset, LedState=4'b1010, Cmd=63 pulsed → Tx shows bytes 0x4C,0x31,0x30,0x31,0x30,0x0D,0x0A, 8N1 LSB-first. Busy is high for exactly 280 cycles.
- Cmd=63 re-pulsed at cycle 100 of a message, and Cmd=114 pulsed → no effect; the output is identical to the undisturbed case.
- LedState changed from 4'b0000 to 4'b1111 one cycle after accept → report still "L0000\r\n".
- Reset_n low during the DATA bits of byte 3 → Tx=1 and Busy=0 in the same cycle. A query after release gives a full, correct message.
- Query on the edge where Busy falls → new start bit one cycle later, no idle gap.
- With LED_STATUS_TX_PARITY_EN and 'L' (0x4C, three ones) → parity bit 1. Each frame is 44 cycles; the message is 308 cycles.
